// File: rtl/control_sequencer_if.sv
// control_sequencer_if -- bundles the sequencer <-> datapath/memory signals.
//   master : the control sequencer (takes run/ir/mem_ready, drives strobes)
//   slave  : the datapath / memory side
// Optional build macro ILLEGAL_TRAP_EN adds the 'illegal' status signal.
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, MARin, IRin, Yin, MDRin, MDRout, HIin, LOin;
  logic        Zhighin, Zlowin, Zhighout, Zlowout, Cout;
  logic        Read, Write;
  logic [3:0]  ALUop;
  logic        ALU_MUL, ALU_DIV;
  logic [3:0]  tstep;
  logic        busy, halted;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  modport master (
`ifdef ILLEGAL_TRAP_EN
    output illegal,
`endif
    input  run, ir, mem_ready,
    output Rin, Rout, PCin, PCout, MARin, IRin, Yin, MDRin, MDRout, HIin, LOin,
    output Zhighin, Zlowin, Zhighout, Zlowout, Cout, Read, Write, ALUop,
    output ALU_MUL, ALU_DIV, tstep, busy, halted
  );

  modport slave (
`ifdef ILLEGAL_TRAP_EN
    input  illegal,
`endif
    output run, ir, mem_ready,
    input  Rin, Rout, PCin, PCout, MARin, IRin, Yin, MDRin, MDRout, HIin, LOin,
    input  Zhighin, Zlowin, Zhighout, Zlowout, Cout, Read, Write, ALUop,
    input  ALU_MUL, ALU_DIV, tstep, busy, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer -- multi-cycle hardwired control unit for the bus CPU.
// Walks fetch T0-T2 and execute T3-T7 per instruction, stalling on the
// memory ready handshake in T1 (fetch), ld T6 and st T7.
// Ports:
//   clock : rising-edge clock
//   clear : synchronous active-low reset
//   bus   : control_sequencer_if.master (run/ir/mem_ready in, strobes out,
//           tstep 0-7 = T0-T7, 8 = IDLE, 9 = HALTED)
// Build macro ILLEGAL_TRAP_EN: undefined opcodes trap to HALTED and set
// the sticky 'illegal' flag; otherwise they execute as a NOP.
module control_sequencer #(
  parameter logic [3:0] ALUOP_ADD   = 4'b0011,
  parameter logic [3:0] ALUOP_INCPC = 4'b1111
) (
  input logic               clock,
  input logic               clear,
  control_sequencer_if.master bus
);
  // State code doubles as the tstep value.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_IDLE = 4'd8, S_HALTED = 4'd9
  } state_t;

  state_t state;

  logic [4:0]  op;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        is_ld, is_st, is_r, is_imm, is_mul, is_div, is_halt, is_def;
  logic        unused_ir;
  state_t      nxt_instr;

  assign op      = bus.ir[31:27];
  assign ra_oh   = 16'h1 << bus.ir[26:23];
  assign rb_oh   = 16'h1 << bus.ir[22:19];
  assign rc_oh   = 16'h1 << bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];

  assign is_ld   = (op == 5'd0);
  assign is_st   = (op == 5'd2);
  assign is_r    = (op >= 5'd3)  && (op <= 5'd11);
  assign is_imm  = (op >= 5'd12) && (op <= 5'd14);
  assign is_mul  = (op == 5'd15);
  assign is_div  = (op == 5'd16);
  assign is_halt = (op == 5'd26);
  assign is_def  = is_ld | is_st | is_r | is_imm | is_mul | is_div | is_halt;

  // Where an instruction goes when it completes.
  assign nxt_instr = bus.run ? S_T0 : S_IDLE;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign bus.illegal = illegal_q;
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= S_IDLE;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE:   if (bus.run) state <= S_T0;
        S_T0:     state <= S_T1;
        S_T1:     if (bus.mem_ready) state <= S_T2;
        S_T2:     state <= S_T3;
        S_T3: begin
          if (is_halt) state <= S_HALTED;
          else if (!is_def) begin
`ifdef ILLEGAL_TRAP_EN
            state     <= S_HALTED;
            illegal_q <= 1'b1;
`else
            state <= nxt_instr;
`endif
          end else state <= S_T4;
        end
        S_T4:     state <= S_T5;
        S_T5:     state <= (is_r || is_imm) ? nxt_instr : S_T6;
        // st's T6 is a register-to-MDR move, so only ld waits here.
        S_T6: begin
          if (is_mul || is_div)           state <= nxt_instr;
          else if (is_st || bus.mem_ready) state <= S_T7;
        end
        S_T7:     if (is_ld || bus.mem_ready) state <= nxt_instr;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.tstep  = state;
  assign bus.busy   = (state <= S_T7);
  assign bus.halted = (state == S_HALTED);

  // Strobes decode from state and ir; mem_ready only gates the capture
  // strobes of a memory-wait step so they pulse exactly once.
  always_comb begin
    bus.Rin = '0;      bus.Rout = '0;
    bus.PCin = 1'b0;   bus.PCout = 1'b0;  bus.MARin = 1'b0;  bus.IRin = 1'b0;
    bus.Yin = 1'b0;    bus.MDRin = 1'b0;  bus.MDRout = 1'b0;
    bus.HIin = 1'b0;   bus.LOin = 1'b0;   bus.Zhighin = 1'b0; bus.Zlowin = 1'b0;
    bus.Zhighout = 1'b0; bus.Zlowout = 1'b0; bus.Cout = 1'b0;
    bus.Read = 1'b0;   bus.Write = 1'b0;  bus.ALUop = 4'b0000;
    bus.ALU_MUL = 1'b0; bus.ALU_DIV = 1'b0;
    case (state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.ALUop = ALUOP_INCPC; bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.Read    = 1'b1;
        bus.MDRin   = bus.mem_ready;
        bus.PCin    = bus.mem_ready;
        bus.Zlowout = bus.mem_ready;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        if (is_mul || is_div) begin
          bus.Rout = ra_oh; bus.Yin = 1'b1;
        end else if (is_ld || is_st || is_r || is_imm) begin
          bus.Rout = rb_oh; bus.Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_ld || is_st) begin
          bus.Cout = 1'b1; bus.ALUop = ALUOP_ADD; bus.Zlowin = 1'b1;
        end else if (is_r) begin
          bus.Rout = rc_oh; bus.ALUop = op[3:0]; bus.Zlowin = 1'b1;
        end else if (is_imm) begin
          bus.Cout = 1'b1; bus.ALUop = op[3:0]; bus.Zlowin = 1'b1;
        end else if (is_mul || is_div) begin
          bus.Rout = rb_oh; bus.ALU_MUL = is_mul; bus.ALU_DIV = is_div;
          bus.Zhighin = 1'b1; bus.Zlowin = 1'b1;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_ld || is_st)       bus.MARin = 1'b1;
        else if (is_r || is_imm)  bus.Rin = ra_oh;
        else                      bus.LOin = 1'b1;
      end
      S_T6: begin
        if (is_ld) begin
          bus.Read = 1'b1; bus.MDRin = bus.mem_ready;
        end else if (is_st) begin
          bus.Rout = ra_oh; bus.MDRin = 1'b1;
        end else begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          bus.MDRout = 1'b1; bus.Rin = ra_oh;
        end else begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed stimulus with a scoreboard: each driven cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_control_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b0;
  control_sequencer_if bus();

  control_sequencer dut (.clock(clock), .clear(clear), .bus(bus.master));

  always #5 clock = ~clock;

  // Strobe vector bit positions
  localparam logic [17:0] PCIN = 18'h1 << 17, PCOUT = 18'h1 << 16, MARIN = 18'h1 << 15,
    IRIN = 18'h1 << 14, YIN = 18'h1 << 13, MDRIN = 18'h1 << 12, MDROUT = 18'h1 << 11,
    HIIN = 18'h1 << 10, LOIN = 18'h1 << 9, ZHIGHIN = 18'h1 << 8, ZLOWIN = 18'h1 << 7,
    ZHIGHOUT = 18'h1 << 6, ZLOWOUT = 18'h1 << 5, COUT = 18'h1 << 4, READ = 18'h1 << 3,
    WRITE = 18'h1 << 2, AMUL = 18'h1 << 1, ADIV = 18'h1;

  localparam logic [31:0] IR_ADD = 32'h19890000;  // add R3,R1,R2
  localparam logic [31:0] IR_MUL = 32'h78900000;  // mul R1,R2
  localparam logic [31:0] IR_HLT = 32'hD0000000;
  localparam logic [31:0] IR_ST  = 32'h10900000;  // st Ra=1 Rb=2
  localparam logic [31:0] IR_LD  = 32'h02280000;  // ld Ra=4 Rb=5
  localparam logic [31:0] IR_IMM = 32'h61180000;  // op 01100 Ra=2 Rb=3
  localparam logic [31:0] IR_BAD = 32'hF8000000;

  typedef struct packed {
    logic [3:0]  ts;
    logic        bsy, hlt;
    logic [17:0] st;
    logic [15:0] rin, rout;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   tag_q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;

  function automatic exp_t mk(input logic [3:0] ts, input logic [17:0] st,
                              input logic [15:0] rin, input logic [15:0] rout,
                              input logic [3:0] op);
    exp_t e;
    e.ts = ts; e.bsy = (ts < 4'd8); e.hlt = (ts == 4'd9);
    e.st = st; e.rin = rin; e.rout = rout; e.op = op; e.ill = 1'b0;
    return e;
  endfunction

  task automatic step(input logic cl, input logic rn, input logic [31:0] i,
                      input logic mr, input logic chk, input exp_t e);
    @(posedge clock);
    #1;
    clear = cl; bus.run = rn; bus.ir = i; bus.mem_ready = mr;
    cyc++;
    if (chk) begin
      q.push_back(e);
      tag_q.push_back(cyc);
    end
  endtask

  task automatic chk(input string what, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", what, got, exp);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e, a;
      int   t;
      e = q.pop_front();
      t = tag_q.pop_front();
      a.ts = bus.tstep; a.bsy = bus.busy; a.hlt = bus.halted;
      a.st = {bus.PCin, bus.PCout, bus.MARin, bus.IRin, bus.Yin, bus.MDRin, bus.MDRout,
              bus.HIin, bus.LOin, bus.Zhighin, bus.Zlowin, bus.Zhighout, bus.Zlowout,
              bus.Cout, bus.Read, bus.Write, bus.ALU_MUL, bus.ALU_DIV};
      a.rin = bus.Rin; a.rout = bus.Rout; a.op = bus.ALUop;
`ifdef ILLEGAL_TRAP_EN
      a.ill = bus.illegal;
`else
      a.ill = 1'b0;
`endif
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cyc%0d: got ts=%0d bsy=%b hlt=%b st=%h rin=%h rout=%h op=%h ill=%b, expected ts=%0d bsy=%b hlt=%b st=%h rin=%h rout=%h op=%h ill=%b",
                 t, a.ts, a.bsy, a.hlt, a.st, a.rin, a.rout, a.op, a.ill,
                 e.ts, e.bsy, e.hlt, e.st, e.rin, e.rout, e.op, e.ill);
      end
    end
  end

  initial begin
    exp_t e;
    exp_t idle, t0, t1w, t1r, t2;
    bus.run = 1'b1; bus.ir = '0; bus.mem_ready = 1'b1;
    idle = mk(4'd8, 18'h0, 16'h0, 16'h0, 4'h0);
    t0   = mk(4'd0, PCOUT | MARIN | ZLOWIN, 16'h0, 16'h0, 4'hF);
    t1w  = mk(4'd1, READ, 16'h0, 16'h0, 4'h0);
    t1r  = mk(4'd1, READ | PCIN | ZLOWOUT | MDRIN, 16'h0, 16'h0, 4'h0);
    t2   = mk(4'd2, MDROUT | IRIN, 16'h0, 16'h0, 4'h0);

    // Reset held two cycles with run=1, then release
    step(0, 1, 32'h0, 1, 0, '0);
    step(0, 1, 32'h0, 1, 1, idle);
    @(negedge clock);
    chk("reset tstep/busy/halted/Read/Write",
        {52'h0, bus.tstep, bus.busy, bus.halted, bus.Read, bus.Write, bus.ALUop},
        {52'h0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("reset strobes",
        {14'h0, bus.PCin, bus.PCout, bus.MARin, bus.IRin, bus.Yin, bus.MDRin, bus.MDRout,
         bus.HIin, bus.LOin, bus.Zhighin, bus.Zlowin, bus.Zhighout, bus.Zlowout, bus.Cout,
         bus.Rin, bus.Rout},
        64'h0);
    step(1, 1, 32'h0, 1, 1, idle);
    // add R3,R1,R2: 6 cycles T0-T5
    step(1, 1, IR_ADD, 1, 1, t0);
    step(1, 1, IR_ADD, 1, 1, t1r);
    step(1, 1, IR_ADD, 1, 1, t2);
    step(1, 1, IR_ADD, 1, 1, mk(4'd3, YIN, 16'h0, 16'h0002, 4'h0));
    step(1, 1, IR_ADD, 1, 1, mk(4'd4, ZLOWIN, 16'h0, 16'h0004, 4'h3));
    step(1, 1, IR_ADD, 1, 1, mk(4'd5, ZLOWOUT, 16'h0008, 16'h0, 4'h0));
    // mul with a 3-cycle fetch stall; run dropped so it returns to IDLE
    step(1, 1, IR_MUL, 1, 1, t0);
    step(1, 1, IR_MUL, 0, 1, t1w);
    step(1, 1, IR_MUL, 0, 1, t1w);
    step(1, 1, IR_MUL, 0, 1, t1w);
    step(1, 1, IR_MUL, 1, 1, t1r);
    step(1, 1, IR_MUL, 1, 1, t2);
    step(1, 1, IR_MUL, 1, 1, mk(4'd3, YIN, 16'h0, 16'h0002, 4'h0));
    step(1, 1, IR_MUL, 1, 1, mk(4'd4, AMUL | ZHIGHIN | ZLOWIN, 16'h0, 16'h0004, 4'h0));
    step(1, 1, IR_MUL, 1, 1, mk(4'd5, ZLOWOUT | LOIN, 16'h0, 16'h0, 4'h0));
    step(1, 0, IR_MUL, 1, 1, mk(4'd6, ZHIGHOUT | HIIN, 16'h0, 16'h0, 4'h0));
    step(1, 0, IR_HLT, 1, 1, idle);
    step(1, 1, IR_HLT, 1, 1, idle);
    // halt: HALTED ignores run, only reset leaves
    step(1, 1, IR_HLT, 1, 1, t0);
    step(1, 1, IR_HLT, 1, 1, t1r);
    step(1, 1, IR_HLT, 1, 1, t2);
    step(1, 1, IR_HLT, 1, 1, mk(4'd3, 18'h0, 16'h0, 16'h0, 4'h0));
    step(1, 1, IR_HLT, 1, 1, mk(4'd9, 18'h0, 16'h0, 16'h0, 4'h0));
    step(0, 1, IR_HLT, 1, 1, mk(4'd9, 18'h0, 16'h0, 16'h0, 4'h0));
    step(1, 1, IR_ST, 1, 1, idle);
    // st, reset while Write waits on mem_ready
    step(1, 1, IR_ST, 1, 1, t0);
    step(1, 1, IR_ST, 1, 1, t1r);
    step(1, 1, IR_ST, 1, 1, t2);
    step(1, 1, IR_ST, 1, 1, mk(4'd3, YIN, 16'h0, 16'h0004, 4'h0));
    step(1, 1, IR_ST, 1, 1, mk(4'd4, COUT | ZLOWIN, 16'h0, 16'h0, 4'h3));
    step(1, 1, IR_ST, 1, 1, mk(4'd5, ZLOWOUT | MARIN, 16'h0, 16'h0, 4'h0));
    step(1, 1, IR_ST, 0, 1, mk(4'd6, MDRIN, 16'h0, 16'h0002, 4'h0));
    step(1, 1, IR_ST, 0, 1, mk(4'd7, WRITE, 16'h0, 16'h0, 4'h0));
    step(0, 1, IR_ST, 0, 1, mk(4'd7, WRITE, 16'h0, 16'h0, 4'h0));
    step(1, 1, IR_LD, 0, 1, idle);
    @(negedge clock);
    chk("expired wait Write/Read/tstep/busy",
        {56'h0, bus.Write, bus.Read, bus.busy, 1'b0, bus.tstep},
        {56'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8});
    // ld with a 1-cycle data stall in T6
    step(1, 1, IR_LD, 1, 1, t0);
    step(1, 1, IR_LD, 1, 1, t1r);
    step(1, 1, IR_LD, 1, 1, t2);
    step(1, 1, IR_LD, 1, 1, mk(4'd3, YIN, 16'h0, 16'h0020, 4'h0));
    step(1, 1, IR_LD, 1, 1, mk(4'd4, COUT | ZLOWIN, 16'h0, 16'h0, 4'h3));
    step(1, 1, IR_LD, 1, 1, mk(4'd5, ZLOWOUT | MARIN, 16'h0, 16'h0, 4'h0));
    step(1, 1, IR_LD, 0, 1, mk(4'd6, READ, 16'h0, 16'h0, 4'h0));
    step(1, 1, IR_LD, 1, 1, mk(4'd6, READ | MDRIN, 16'h0, 16'h0, 4'h0));
    step(1, 1, IR_LD, 1, 1, mk(4'd7, MDROUT, 16'h0010, 16'h0, 4'h0));
    // immediate form: Cout replaces Rout[Rc], ALUop from opcode
    step(1, 1, IR_IMM, 1, 1, t0);
    step(1, 1, IR_IMM, 1, 1, t1r);
    step(1, 1, IR_IMM, 1, 1, t2);
    step(1, 1, IR_IMM, 1, 1, mk(4'd3, YIN, 16'h0, 16'h0008, 4'h0));
    step(1, 1, IR_IMM, 1, 1, mk(4'd4, COUT | ZLOWIN, 16'h0, 16'h0, 4'hC));
    step(1, 1, IR_IMM, 1, 1, mk(4'd5, ZLOWOUT, 16'h0004, 16'h0, 4'h0));
    // undefined opcode
    step(1, 1, IR_BAD, 1, 1, t0);
    step(1, 1, IR_BAD, 1, 1, t1r);
    step(1, 1, IR_BAD, 1, 1, t2);
    step(1, 0, IR_BAD, 1, 1, mk(4'd3, 18'h0, 16'h0, 16'h0, 4'h0));
`ifdef ILLEGAL_TRAP_EN
    e = mk(4'd9, 18'h0, 16'h0, 16'h0, 4'h0); e.ill = 1'b1;
    step(1, 1, IR_BAD, 1, 1, e);
    step(0, 1, IR_BAD, 1, 1, e);
    step(1, 0, IR_BAD, 1, 1, idle);
`else
    e = idle;
    step(1, 0, IR_BAD, 1, 1, e);
    step(1, 0, IR_BAD, 1, 1, idle);
`endif
    @(posedge clock);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
